// File: rtl/sctag_dir_ctl_gen.sv
// rtl/sctag_dir_ctl_gen.sv - L2 tag directory panel enables, read-select staging and warm-clear sequencer
module sctag_dir_ctl_gen #(
  parameter int NPANEL = 4,
  parameter int NENTRY = 64,
  parameter int ENTW   = 6,
  parameter int MASKW  = 8
) (
  input  logic              rclk,
  input  logic              arst_l,
  input  logic              se,
  input  logic              si,
  input  logic              sehold,
  output logic              so,
  input  logic [NPANEL-1:0] lkup_en_c4_buf,
  input  logic [MASKW-1:0]  inval_mask_c4_buf,
  input  logic [NPANEL-1:0] rw_dec_c4_buf,
  input  logic              rd_en_c4_buf,
  input  logic              wr_en_c4_buf,
  input  logic [ENTW-1:0]   rw_entry_c4_buf,
  input  logic              dir_clear_c4_buf,
  output logic [NPANEL-1:0] rd_data_en_c4,
  output logic [NPANEL-1:0] wr_data_en_c4,
  output logic [NPANEL-1:0] cam_en_c4,
  output logic [ENTW-1:0]   rw_entry_c4,
  output logic [MASKW-1:0]  inval_mask_c4,
  output logic              warm_rst_c4,
  output logic [NPANEL-1:0] rd_data_sel_c5,
  output logic              rd_data_sel_left_c6,
  output logic              rd_data_sel_right_c6,
  output logic              clr_busy,
  output logic              clr_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} state_e;

  localparam int CHW = 2 + ENTW + NPANEL + 2;

  state_e            state_q, state_d;
  logic [ENTW-1:0]   cnt_q, cnt_d;
  logic [NPANEL-1:0] c5_q, c5_d;
  logic              left_q, left_d;
  logic              right_q, right_d;
  logic [CHW-1:0]    chain_q;
  logic [CHW-1:0]    scan_d;
  logic              busy;

  assign chain_q = {state_q, cnt_q, c5_q, left_q, right_q};
  assign scan_d  = {chain_q[CHW-2:0], si};
  assign so      = chain_q[CHW-1];

  always_comb begin
    busy    = (state_q == CLEAR);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!sehold) begin
      case (state_q)
        IDLE: begin
          if (dir_clear_c4_buf) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
        CLEAR: begin
          // Natural wrap of cnt leaves it at 0 on the way into DONE
          cnt_d = cnt_q + ENTW'(1);
          if (cnt_q == ENTW'(NENTRY - 1)) state_d = DONE;
        end
        DONE: begin
          state_d = dir_clear_c4_buf ? CLEAR : IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (busy) begin
      rd_data_en_c4 = '0;
      wr_data_en_c4 = '1;
      cam_en_c4     = '0;
      rw_entry_c4   = cnt_q;
    end else begin
      rd_data_en_c4 = {NPANEL{rd_en_c4_buf}} & rw_dec_c4_buf;
      wr_data_en_c4 = {NPANEL{wr_en_c4_buf & ~dir_clear_c4_buf}} & rw_dec_c4_buf;
      cam_en_c4     = lkup_en_c4_buf;
      rw_entry_c4   = rw_entry_c4_buf;
    end

    // Only the panel 0/1 select flops honour sehold
    c5_d = rd_data_en_c4;
    if (sehold) c5_d[1:0] = c5_q[1:0];

    left_d  = 1'b0;
    right_d = 1'b0;
    for (int i = 0; i < NPANEL; i += 2) left_d  = left_d  | c5_q[i];
    for (int i = 1; i < NPANEL; i += 2) right_d = right_d | c5_q[i];

    if (se) begin
      state_d = state_e'(scan_d[CHW-1 -: 2]);
      cnt_d   = scan_d[CHW-3 -: ENTW];
      c5_d    = scan_d[NPANEL+1:2];
      left_d  = scan_d[1];
      right_d = scan_d[0];
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c5_q    <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c5_q    <= c5_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign inval_mask_c4        = inval_mask_c4_buf;
  assign warm_rst_c4          = busy;
  assign clr_busy             = busy;
  assign clr_done             = (state_q == DONE);
  assign rd_data_sel_c5       = c5_q;
  assign rd_data_sel_left_c6  = left_q;
  assign rd_data_sel_right_c6 = right_q;

endmodule

// File: doc/sctag_dir_ctl_gen.md
# sctag_dir_ctl_gen

Parametrised directory panel control for the L2 tag directory. It generates the per-panel read, write and CAM enables at C4, and the staged read-data selects at C5 and C6, for NPANEL directory panels. It adds a multi-cycle warm-reset clear sequencer that walks every directory entry and resets its valid bit, with functional writes blocked for the whole sequence. It sits between the C4 buffer stage and the directory panels.

## Interface
- NPANEL, 4, number of directory panels; even, ≥2; even index = left column, odd = right column
- NENTRY, 64, entries per panel; power of 2, ≥2
- ENTW, 6, entry index width; ENTW = log2(NENTRY)
- MASKW, 8, invalidate mask width

One clock; reset is asynchronous and active-low.
- rclk  in  1  clock, all flops rising edge
- arst_l  in  1  async active-low reset
- se, si, sehold  in  1 each  scan enable, scan in, scan hold
- so  out  1  scan out
- lkup_en_c4_buf  in  NPANEL  per-panel lookup request
- inval_mask_c4_buf  in  MASKW  invalidate mask
- rw_dec_c4_buf  in  NPANEL  per-panel read/write decode
- rd_en_c4_buf, wr_en_c4_buf  in  1 each  read / write strobe
- rw_entry_c4_buf  in  ENTW  functional entry index
- dir_clear_c4_buf  in  1  warm-clear request, level or pulse
- rd_data_en_c4, wr_data_en_c4, cam_en_c4  out  NPANEL each  panel enables
- rw_entry_c4  out  ENTW  entry index to panels
- inval_mask_c4  out  MASKW  pass-through of inval_mask_c4_buf
- warm_rst_c4  out  1  valid-bit reset qualifier to panels
- rd_data_sel_c5  out  NPANEL  registered rd_data_en
- rd_data_sel_left_c6, rd_data_sel_right_c6  out  1 each  column selects
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle completion pulse

## Operation
- Sequencer states: IDLE, CLEAR, DONE. Counter cnt is ENTW bits wide.
- IDLE:
  - If dir_clear_c4_buf=1 → CLEAR with cnt=0.
  - Otherwise stay in IDLE.
- CLEAR:
  - cnt increments by 1 each cycle.
  - When cnt=NENTRY-1 → DONE; the counter wraps to 0.
  - dir_clear_c4_buf is ignored in this state.
- DONE:
  - Lasts one cycle.
  - If dir_clear_c4_buf=1 → CLEAR with cnt=0; otherwise → IDLE.
- Functional mode (state≠CLEAR):
  - rd_data_en_c4 = {NPANEL{rd_en}} & rw_dec.
  - wr_data_en_c4 = {NPANEL{wr_en & ~dir_clear_c4_buf}} & rw_dec. A write in the same cycle as a clear request is dropped.
  - cam_en_c4 = lkup_en_c4_buf.
  - rw_entry_c4 = rw_entry_c4_buf.
  - warm_rst_c4 = 0.
- CLEAR mode:
  - warm_rst_c4 = 1.
  - wr_data_en_c4 = all ones.
  - rw_entry_c4 = cnt.
  - rd_data_en_c4 = 0 and cam_en_c4 = 0; functional requests are dropped, not queued.
- inval_mask_c4 is always a pass-through.
- clr_busy = (state==CLEAR).
- clr_done = (state==DONE).
- Read-select pipeline:
  - rd_data_sel_c5 <= rd_data_en_c4.
  - rd_data_sel_left_c6 <= OR of rd_data_sel_c5 over even indices.
  - rd_data_sel_right_c6 <= OR of rd_data_sel_c5 over odd indices.
- sehold=1 freezes the rd_data_sel_c5 flops for panels 0 and 1 only, together with the sequencer state and cnt. The C6 flops and the remaining C5 flops keep updating.
- Scan: all flops are stitched si→so; se=1 selects the scan path.

## Timing
- All C4 outputs are combinational from the inputs and the registered state. There is no C4 latency.
- rd_data_sel_c5 is valid 1 cycle after rd_data_en_c4. The C6 selects are valid 2 cycles after it.
- Clear request sampled at edge t:
  - CLEAR occupies cycles t+1 .. t+NENTRY, with rw_entry_c4 = 0..NENTRY-1 in order.
  - clr_done is high in cycle t+NENTRY+1.
  - The earliest functional write is in cycle t+NENTRY+1.
- Reset (arst_l=0) takes effect immediately, including mid-clear: state=IDLE, cnt=0, all flops 0.
  - Reset values: rd_data_sel_c5=0, both C6 selects=0, clr_busy=0, clr_done=0, warm_rst_c4=0.
  - C4 enables follow the functional equations during reset.
  - An aborted clear is not resumed; software reissues it.
- sehold asserted during CLEAR stretches the sequence by the number of held cycles. rw_entry_c4 stays constant and the write enables stay asserted while held.

## Test plan
- NPANEL=4, rd_en=1, rw_dec=0100 → rd_data_en_c4=0100. One cycle later rd_data_sel_c5=0100; two cycles later left_c6=1, right_c6=0.
- wr_en=1, rw_dec=0010, dir_clear=1 in the same cycle → wr_data_en_c4=0000. Next cycle warm_rst_c4=1, wr_data_en_c4=1111, rw_entry_c4=0.
- Full clear, NENTRY=64 → clr_busy high 64 cycles, rw_entry_c4 steps 0..63 with no gaps, clr_done a single pulse, rd/cam enables 0 throughout.
- arst_l low at cnt=17 → clr_busy=0 immediately. After release, functional rd_en=1 passes through on the first cycle.
- sehold high for 3 cycles at cnt=10 → rw_entry_c4 holds 10 for 4 cycles and total busy is 67 cycles. rd_data_sel_c5[1:0] is held while [3:2] updates.
- dir_clear asserted during DONE → re-enters CLEAR with cnt=0 and no IDLE cycle in between. dir_clear held during CLEAR causes no restart.
